udp_decoder: RTL
================

// Module: udp_decoder
// PURPOSE
//  Receive-side counterpart of the UDP transmit path. Takes the UDP segment byte stream from the
//  IPv4 receive stage and parses the 8-byte header. Filters on destination port, strips Ethernet
//  padding and forwards the payload bytes. Reports per-datagram status (done/ok/error) to the
//  application layer.
// PARAMETERS
//  HTGv6_UDP_PORT  16'd10_002  local port; only datagrams with this destination port are forwarded
// PORTS
//  CLK                 in   1   receive clock (RX_CLK); sole clock
//  RST                 in   1   reset, synchronous, active-high
//  UDP_EN              in   1   IP layer: current frame carries a UDP segment; sampled on first valid byte
//  IN_DATA             in   8   segment byte, header first, MSB-first fields
//  IN_DATA_VLD         in   1   byte strobe; high contiguously for the whole segment, low between frames
//  UDP_PSEUDO_HEADER_CHECKSUM in 16 folded ones-complement sum of the IPv4 pseudo header; stable during frame
//  UDP_SRC_PORT        out  16  captured source port; valid from HDR2 until next frame
//  UDP_DST_PORT        out  16  captured destination port
//  UDP_LENGTH          out  16  captured length field (header+payload)
//  OUT_DATA            out  8   payload byte
//  OUT_DATA_VLD        out  1   payload strobe, 1 cycle latency from IN_DATA
//  UDP_DONE            out  1   one-cycle pulse at end of every frame accepted with UDP_EN=1
//  UDP_STATUS          out  3   valid with UDP_DONE: [0] port mismatch, [1] short/length error, [2] checksum error
// BEHAVIOUR
//  - Reset: all outputs 0; state HDR0; accumulator and byte counter 0. RST mid-frame aborts with no
//    DONE; the remainder of that frame is skipped until IN_DATA_VLD low.
//  - States: HDR0..HDR7, DATA, PAD, SKIP, DONE.
//  - HDR0: on IN_DATA_VLD & UDP_EN -> HDR1. On IN_DATA_VLD & !UDP_EN -> SKIP.
//  - HDR0-7 capture src[15:8], src[7:0], dst, length, checksum bytes in order.
//  - HDR7 -> DATA if length>8. Else PAD; a length of exactly 8 gives an empty payload.
//  - Length < 8 sets status[1]. Dst != HTGv6_UDP_PORT sets status[0]. Either goes to PAD with no payload output.
//  - DATA: forward IN_DATA; count bytes. After byte number (length-8) -> PAD.
//  - PAD: consume trailing bytes without output until VLD low -> DONE.
//  - VLD low in any HDRn or DATA state -> DONE with status[1]=1. No further payload is forwarded.
//  - DONE: pulse UDP_DONE for exactly 1 cycle with UDP_STATUS; -> HDR0. A VLD rising in the DONE cycle is
//    not possible: at least 1 idle cycle is guaranteed by the MAC.
//  - SKIP: ignore bytes, no DONE; VLD low -> HDR0.
//  - Checksum arithmetic (20-bit accumulator):
//    - Sum the 16-bit big-endian words of header and payload, plus the pseudo-header input.
//    - An odd final byte is padded with 8'h00 low.
//    - Pad bytes beyond length are excluded.
//    - End-around fold twice; result must equal 16'hFFFF.
//    - A received checksum field of 16'h0000 means "not computed" and always passes.
// CONFIGURATION
//  UDP_DECODER_CHECKSUM_EN defined: checksum accumulated and checked; failure sets status[2].
//    A failed payload has already been forwarded; the consumer discards it on status[2].
//  Undefined: no accumulator is synthesised; status[2] is tied 0. All other behaviour is identical.
// STRUCTURE
//  Package udp_pkg:
//    - state encodings, gray-coded 4-bit
//    - UDP_HDR_LEN=8
//    - status bit indices ST_PORT_ERR=0, ST_LEN_ERR=1, ST_CSUM_ERR=2
//  Sub-module udp_csum_acc (under the macro):
//    - ports: clr, byte strobe, byte, odd/even phase, pseudo input
//    - outputs: folded 16-bit sum, ok flag
//    - shared later with the transmit path for data checksums
// TESTING
//  1. Hit: src 0x2712, dst 0x2712, len 0x000C, csum 0x1432, payload DE AD BE EF, pseudo 0x0000
//     -> OUT_DATA DE,AD,BE,EF on 4 consecutive cycles, 1 cycle late; DONE with status 3'b000.
//  2. Same as 1 with dst 0x2713 -> no OUT_DATA_VLD; DONE with status 3'b001.
//  3. Same as 1 plus 6 trailing pad bytes 00 -> 4 payload bytes only; DONE with status 3'b000.
//  4. Same as 1 with csum 0x1433 -> payload forwarded; status 3'b100 (macro on) or 3'b000 (macro off).
//     With csum 0x0000 -> status 3'b000.
//  5. len 0x0010 but VLD drops after 2 payload bytes -> DE,AD out; DONE with status[1]=1.
//     VLD dropping after header byte 3 -> status[1]=1, no payload.
//  6. UDP_EN=0 frame -> no output, no DONE. RST asserted mid-DATA -> outputs 0 next cycle, no DONE;
//     the following good frame decodes as in scenario 1.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP receive decoder: gray-coded FSM states,
// header length and status bit positions.
package udp_pkg;

    typedef enum logic [3:0] {
        S_HDR0 = 4'b0000,
        S_HDR1 = 4'b0001,
        S_HDR2 = 4'b0011,
        S_HDR3 = 4'b0010,
        S_HDR4 = 4'b0110,
        S_HDR5 = 4'b0111,
        S_HDR6 = 4'b0101,
        S_HDR7 = 4'b0100,
        S_DATA = 4'b1100,
        S_PAD  = 4'b1101,
        S_DONE = 4'b1111,
        S_SKIP = 4'b1110
    } state_t;

    localparam int UDP_HDR_LEN = 8;

    localparam int ST_PORT_ERR = 0;
    localparam int ST_LEN_ERR  = 1;
    localparam int ST_CSUM_ERR = 2;

    function automatic state_t hdr_next(input state_t s);
        case (s)
            S_HDR0:  return S_HDR1;
            S_HDR1:  return S_HDR2;
            S_HDR2:  return S_HDR3;
            S_HDR3:  return S_HDR4;
            S_HDR4:  return S_HDR5;
            S_HDR5:  return S_HDR6;
            S_HDR6:  return S_HDR7;
            default: return S_DATA;
        endcase
    endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// Internet-checksum accumulator over a byte stream (big-endian 16-bit words) plus an
// external pseudo-header sum. Also intended for the transmit-side data checksum.
module udp_csum_acc (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    input  logic        i_odd,
    input  logic [15:0] i_pseudo,
    output logic [15:0] o_sum,
    output logic        o_ok
);

    logic [19:0] r_acc;
    logic [19:0] w_base;
    logic [19:0] w_addend;
    logic [20:0] w_tot;
    logic [16:0] w_f1;
    logic [15:0] w_f2;

    // Carries are folded back on every add so long datagrams cannot overflow 20 bits.
    assign w_base   = i_clr ? 20'd0 : ({4'b0, r_acc[15:0]} + {16'b0, r_acc[19:16]});
    assign w_addend = i_odd ? {12'b0, i_byte} : {4'b0, i_byte, 8'b0};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_byte_vld) begin
            r_acc <= w_base + w_addend;
        end else if (i_clr) begin
            r_acc <= '0;
        end
    end

    assign w_tot = {1'b0, r_acc} + {5'b0, i_pseudo};
    assign w_f1  = {1'b0, w_tot[15:0]} + {12'b0, w_tot[20:16]};
    assign w_f2  = w_f1[15:0] + {15'b0, w_f1[16]};
    assign o_sum = w_f2;
    assign o_ok  = (w_f2 == 16'hFFFF);

endmodule

// File: rtl/udp_decoder.sv
// UDP receive decoder: parses the header, filters on destination port, forwards payload
// and reports per-datagram status. Define UDP_DECODER_CHECKSUM_EN to check the checksum.
//
// state | meaning
// HDR0  | idle / first header byte (src port hi)
// HDR1-7| remaining header bytes: src lo, dst, length, checksum
// DATA  | forwarding payload bytes
// PAD   | consuming bytes beyond length (or of a rejected datagram)
// DONE  | one-cycle status report
// SKIP  | ignoring a non-UDP or partially-seen frame
module udp_decoder #(
    parameter logic [15:0] HTGv6_UDP_PORT = 16'd10_002
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_udp_en,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_data_vld,
    input  logic [15:0] i_udp_pseudo_header_checksum,
    output logic [15:0] o_udp_src_port,
    output logic [15:0] o_udp_dst_port,
    output logic [15:0] o_udp_length,
    output logic [7:0]  o_out_data,
    output logic        o_out_data_vld,
    output logic        o_udp_done,
    output logic [2:0]  o_udp_status
);
    import udp_pkg::*;

    state_t      r_state;
    state_t      w_next;
    logic        r_vld_q;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_len;
    logic [15:0] r_remain;
    logic [1:0]  r_status;
    logic [7:0]  r_out_data;
    logic        r_out_vld;
    logic        w_start;
    logic        w_set_port;
    logic        w_set_len;
    logic        w_fwd;
    logic        w_csum_err;

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_set_port = 1'b0;
        w_set_len  = 1'b0;
        w_fwd      = 1'b0;
        case (r_state)
            S_HDR0: begin
                // r_vld_q high means we are mid-frame (e.g. just out of reset): skip it.
                if (i_in_data_vld) begin
                    if (i_udp_en && !r_vld_q) begin
                        w_start = 1'b1;
                        w_next  = S_HDR1;
                    end else begin
                        w_next = S_SKIP;
                    end
                end
            end
            S_HDR1, S_HDR2, S_HDR3, S_HDR4, S_HDR5, S_HDR6: begin
                if (i_in_data_vld) begin
                    w_next = hdr_next(r_state);
                end else begin
                    w_set_len = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_HDR7: begin
                if (i_in_data_vld) begin
                    w_set_len  = (r_len < 16'(UDP_HDR_LEN));
                    w_set_port = (r_dst != HTGv6_UDP_PORT);
                    if (w_set_len || w_set_port || (r_len == 16'(UDP_HDR_LEN))) begin
                        w_next = S_PAD;
                    end else begin
                        w_next = S_DATA;
                    end
                end else begin
                    w_set_len = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DATA: begin
                if (i_in_data_vld) begin
                    w_fwd = 1'b1;
                    if (r_remain == 16'd1) begin
                        w_next = S_PAD;
                    end
                end else begin
                    w_set_len = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_PAD:   if (!i_in_data_vld) w_next = S_DONE;
            S_SKIP:  if (!i_in_data_vld) w_next = S_HDR0;
            S_DONE:  w_next = S_HDR0;
            default: w_next = S_HDR0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_HDR0;
            r_vld_q    <= 1'b1;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_remain   <= '0;
            r_status   <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_vld_q   <= i_in_data_vld;
            r_out_vld <= w_fwd;
            if (w_fwd) r_out_data <= i_in_data;
            if (w_start) begin
                r_src[15:8] <= i_in_data;
                r_status    <= '0;
            end else begin
                if (w_set_port) r_status[ST_PORT_ERR] <= 1'b1;
                if (w_set_len)  r_status[ST_LEN_ERR]  <= 1'b1;
            end
            if (i_in_data_vld) begin
                case (r_state)
                    S_HDR1:  r_src[7:0]  <= i_in_data;
                    S_HDR2:  r_dst[15:8] <= i_in_data;
                    S_HDR3:  r_dst[7:0]  <= i_in_data;
                    S_HDR4:  r_len[15:8] <= i_in_data;
                    S_HDR5:  r_len[7:0]  <= i_in_data;
                    S_HDR7:  r_remain    <= r_len - 16'(UDP_HDR_LEN);
                    S_DATA:  r_remain    <= r_remain - 16'd1;
                    default: ;
                endcase
            end
        end
    end

`ifdef UDP_DECODER_CHECKSUM_EN
    logic [15:0] r_csum;
    logic        r_phase;
    logic        w_acc_en;
    logic        w_ok;
    logic [15:0] w_sum;
    logic        w_unused_sum;

    // Only header and in-length payload bytes are summed; PAD bytes never are.
    assign w_acc_en = i_in_data_vld &&
                      (w_start || r_state == S_DATA ||
                       (r_state inside {S_HDR1, S_HDR2, S_HDR3, S_HDR4, S_HDR5, S_HDR6, S_HDR7}));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csum  <= '0;
            r_phase <= 1'b0;
        end else begin
            if (w_start) begin
                r_phase <= 1'b1;
            end else if (w_acc_en) begin
                r_phase <= ~r_phase;
            end
            if (i_in_data_vld && r_state == S_HDR6) r_csum[15:8] <= i_in_data;
            if (i_in_data_vld && r_state == S_HDR7) r_csum[7:0]  <= i_in_data;
        end
    end

    udp_csum_acc u_csum_acc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_start),
        .i_byte_vld (w_acc_en),
        .i_byte     (i_in_data),
        .i_odd      (w_start ? 1'b0 : r_phase),
        .i_pseudo   (i_udp_pseudo_header_checksum),
        .o_sum      (w_sum),
        .o_ok       (w_ok)
    );

    assign w_unused_sum = ^w_sum;
    // A zero checksum field means "not computed"; errored datagrams are not checked.
    assign w_csum_err = (r_status == 2'b00) && (r_csum != 16'h0000) && !w_ok;
`else
    logic w_unused_pseudo;
    assign w_unused_pseudo = ^i_udp_pseudo_header_checksum;
    assign w_csum_err      = 1'b0;
`endif

    always_comb begin
        o_udp_status = '0;
        if (r_state == S_DONE) begin
            o_udp_status[ST_PORT_ERR] = r_status[ST_PORT_ERR];
            o_udp_status[ST_LEN_ERR]  = r_status[ST_LEN_ERR];
            o_udp_status[ST_CSUM_ERR] = w_csum_err;
        end
    end

    assign o_udp_done     = (r_state == S_DONE);
    assign o_udp_src_port = r_src;
    assign o_udp_dst_port = r_dst;
    assign o_udp_length   = r_len;
    assign o_out_data     = r_out_data;
    assign o_out_data_vld = r_out_vld;

endmodule
